// File: rtl/mn_spike_event_fifo.sv
// Timestamped spike-event FIFO: tags each motor-neuron spike with the current sim step
// and buffers {ts, id} for a valid/ready consumer. Drops on full are counted, never stored.
module mn_spike_event_fifo #(
    parameter int ID_W       = 16,
    parameter int TS_W       = 16,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                   neuron_clk,
    input  logic                   reset_sim,
    input  logic                   MN_spk,
    input  logic [ID_W-1:0]        spkid_MN,
    input  logic                   sim_tick,
    input  logic                   en,
    input  logic                   clr_ovf,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [TS_W+ID_W-1:0]   rd_data,
    output logic [DEPTH_LOG2:0]    fifo_count,
    output logic [15:0]            overflow_cnt,
    output logic                   overflow
);

    localparam int W = TS_W + ID_W;

    logic [W-1:0]            r_mem [2**DEPTH_LOG2];
    logic [TS_W-1:0]         r_ts;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic [W-1:0]            r_rd_data;
    logic [15:0]             r_ovf_cnt;
    logic                    r_ovf;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_req;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_bypass;
    logic [W-1:0]            w_wr_data;
    logic [DEPTH_LOG2-1:0]   w_rd_addr_next;

    // Count has one extra bit, so its MSB alone marks "full".
    assign w_full    = r_count[DEPTH_LOG2];
    assign w_empty   = (r_count == '0);
    assign w_wr_req  = MN_spk & en;
    assign w_pop     = ~w_empty & rd_ready;
    assign w_push    = w_wr_req & (~w_full | w_pop);
    assign w_drop    = w_wr_req & w_full & ~w_pop;
    assign w_wr_data = {r_ts, spkid_MN};

    assign w_rd_addr_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    // The word being written becomes the next head when the FIFO is empty or
    // its only entry is leaving; RAM cannot supply it yet, so forward it.
    assign w_bypass = w_push & (w_empty | ((r_count == (DEPTH_LOG2+1)'(1)) & w_pop));

    always_ff @(posedge neuron_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge neuron_clk or posedge reset_sim) begin
        if (reset_sim) begin
            r_ts      <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (sim_tick) begin
                r_ts <= r_ts + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head register only moves on a pop or a forwarded first entry,
            // which keeps rd_data stable while the consumer stalls.
            if (w_bypass) begin
                r_rd_data <= w_wr_data;
            end else if (w_pop) begin
                r_rd_data <= r_mem[w_rd_addr_next];
            end
        end
    end

    always_ff @(posedge neuron_clk or posedge reset_sim) begin
        if (reset_sim) begin
            r_ovf_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (clr_ovf) begin
            r_ovf_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_ovf_cnt != 16'hFFFF) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign rd_valid     = ~w_empty;
    assign rd_data      = r_rd_data;
    assign fifo_count   = r_count;
    assign overflow_cnt = r_ovf_cnt;
    assign overflow     = r_ovf;

endmodule
